demux_stream_n: RTL
===================

Name: demux_stream_n

Overview:
Parametrised 1-to-NUM_CH stream demultiplexer with valid/ready handshake on the input and on every output channel. It supports two delivery modes: unicast to a selected channel, or broadcast to all channels. Each channel has a one-entry output register and a saturating transfer counter. It routes activity samples from the capture front-end to per-unit power-estimation lanes, and the counters feed the activity statistics block.

Parameters:
DATA_W, 8, payload width in bits
NUM_CH, 4, number of output channels (2..32; need not be a power of two)
SEL_W, $clog2(NUM_CH), select width (derived; do not override)
CNT_W, 16, width of each per-channel transfer counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept input this cycle
in_data  input  DATA_W  input payload
in_sel  input  SEL_W  target channel index (unicast mode)
in_bcast  input  1  1 = deliver to all channels, in_sel ignored
out_valid  output  NUM_CH  per-channel output valid
out_ready  input  NUM_CH  per-channel downstream ready
out_data  output  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
xfer_cnt  output  NUM_CH*CNT_W  channel i completed-transfer count, [i*CNT_W +: CNT_W]
clr_cnt  input  1  synchronous clear of all xfer_cnt
err_sel  output  1  sticky flag, illegal in_sel accepted

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_data=0, xfer_cnt=0, err_sel=0. in_ready is forced to 0 combinationally while rst=1.
- Reset mid-operation: any words held in channel registers are discarded, with no drain.
- Channel free: free[i] = !out_valid[i] | out_ready[i]. A register being drained this cycle can be reloaded in the same cycle, giving full throughput.
- Target mask:
  - unicast: one-hot(in_sel)
  - broadcast: all ones
  - illegal in_sel (>= NUM_CH, possible only when NUM_CH is not a power of two): all zeros
- in_ready = !rst & (AND of free[i] over all i in the target mask). For an all-zero mask, in_ready=1. in_ready depends combinationally on out_ready; there is no combinational path from in_valid to in_ready.
- Accept = in_valid & in_ready. On accept, every targeted channel loads in_data and sets out_valid[i]=1 on the next edge. Latency is 1 cycle from accept to out_valid.
- Broadcast is all-or-nothing: it stalls until every channel is free in the same cycle. Partial delivery is never allowed.
- Output handshake: out_valid[i] & out_ready[i] completes a transfer. out_valid[i] clears on the next edge unless the channel is reloaded in that same cycle.
- out_valid[i] and out_data[i] are stable while out_valid[i]=1 & out_ready[i]=0.
- Non-targeted channels are untouched. out_data of an idle channel holds its last value (not zeroed), to minimise toggling.
- Illegal select: the word is accepted and dropped, and err_sel sets to 1 on the next edge. err_sel clears only on rst.
- Counters: xfer_cnt[i] += 1 on each completed output transfer and saturates at 2^CNT_W-1 (no wrap).
  - clr_cnt=1 sets all counters to 0 on the next edge.
  - clr_cnt together with a transfer on the same edge gives 0; clear wins and the transfer is not counted.
- No internal state machine beyond the per-channel full bit. Expected implementation: NUM_CH register slices generated by a loop, plus shared mask/ready logic.

Test Plan:
- Unicast sweep (NUM_CH=4, DATA_W=8, all out_ready=1): send 0xA0..0xA3 with in_sel=0..3 back-to-back.
  - Required: out_valid[k] pulses one cycle after each accept with data 0xA0+k; in_ready stays 1.
  - Required: xfer_cnt = 1,1,1,1.
- Backpressure: out_ready[2]=0; send 0x11 then 0x22, both with sel=2.
  - Required: 0x11 is held on ch2 and in_ready=0 for the second word.
  - Required: after out_ready[2]=1 for one cycle, 0x22 appears the next cycle; other channels are unaffected.
- Broadcast stall: ch1 full with out_ready[1]=0; send 0x5C with in_bcast=1.
  - Required: no channel loads while ch1 is blocked.
  - Required: when ch1 drains, all four channels show 0x5C together one cycle later.
- Illegal select (NUM_CH=3, SEL_W=2): send sel=3, data 0xFF.
  - Required: in_ready=1, no out_valid asserts, err_sel=1 next cycle and stays 1 until rst.
- Counters (CNT_W=4): 17 transfers on ch0.
  - Required: xfer_cnt[0] saturates at 15.
  - Required: clr_cnt asserted on the same edge as a transfer gives 0.
- Reset mid-stream: assert rst while ch0 and ch3 are valid.
  - Required: next edge out_valid=0, out_data=0, counters 0, err_sel 0; in_ready=0 during rst.

Source files
------------

// File: rtl/demux_stream_n.sv
`default_nettype none
// ============================================================================
// Module   : demux_stream_n
// Purpose  : 1-to-NUM_CH valid/ready stream demultiplexer with unicast and
//            all-or-nothing broadcast delivery, a one-entry output register
//            per channel, saturating per-channel transfer counters and a
//            sticky illegal-select flag.
// Revision : 1.0 - initial release
// ============================================================================
module demux_stream_n #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH*CNT_W-1:0]  xfer_cnt,
    input  logic                     clr_cnt,
    output logic                     err_sel
);

    localparam logic [NUM_CH-1:0] c_ONE     = NUM_CH'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

    logic [NUM_CH-1:0] w_free;
    logic [NUM_CH-1:0] w_onehot;
    logic [NUM_CH-1:0] w_mask;
    logic              w_sel_legal;
    logic              w_blocked;
    logic              w_accept;
    logic              r_err_q;
    logic              w_err_d;

    // Target mask: a select past the last channel shifts the one-hot out of
    // range, so an all-zero one-hot doubles as the illegal-select detector.
    always_comb begin
        w_onehot    = c_ONE << in_sel;
        w_sel_legal = |w_onehot;
        w_mask      = '0;
        if (in_bcast) begin
            w_mask = '1;
        end else begin
            w_mask = w_onehot;
        end
    end

    // Ready only when every targeted channel is free; independent of in_valid.
    always_comb begin
        w_blocked = |(w_mask & ~w_free);
        in_ready  = ~rst & ~w_blocked;
        w_accept  = in_valid & in_ready;
        w_err_d   = r_err_q | (w_accept & ~in_bcast & ~w_sel_legal);
    end

    // Sticky illegal-select flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_q <= 1'b0;
        end else begin
            r_err_q <= w_err_d;
        end
    end

    assign err_sel = r_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic              r_full_q;
        logic              w_full_d;
        logic [DATA_W-1:0] r_data_q;
        logic [DATA_W-1:0] w_data_d;
        logic [CNT_W-1:0]  r_cnt_q;
        logic [CNT_W-1:0]  w_cnt_d;
        logic              w_load;
        logic              w_xfer;

        assign w_free[i] = ~r_full_q | out_ready[i];
        assign w_load    = w_accept & w_mask[i];
        assign w_xfer    = r_full_q & out_ready[i];

        // Next state: a reload wins over a drain; idle data is held, and a
        // counter clear takes priority over a same-cycle transfer.
        always_comb begin
            w_full_d = r_full_q;
            w_data_d = r_data_q;
            w_cnt_d  = r_cnt_q;
            if (w_load) begin
                w_full_d = 1'b1;
                w_data_d = in_data;
            end else if (w_xfer) begin
                w_full_d = 1'b0;
            end
            if (clr_cnt) begin
                w_cnt_d = '0;
            end else if (w_xfer && (r_cnt_q != c_CNT_MAX)) begin
                w_cnt_d = r_cnt_q + CNT_W'(1);
            end
        end

        // Channel register slice; reset discards any held word.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_full_q <= 1'b0;
                r_data_q <= '0;
                r_cnt_q  <= '0;
            end else begin
                r_full_q <= w_full_d;
                r_data_q <= w_data_d;
                r_cnt_q  <= w_cnt_d;
            end
        end

        assign out_valid[i]                  = r_full_q;
        assign out_data[i*DATA_W +: DATA_W]  = r_data_q;
        assign xfer_cnt[i*CNT_W +: CNT_W]    = r_cnt_q;
    end

endmodule
`default_nettype wire
